bpsk_rx_ber: RTL and testbench

//  Receive end of the BPSK pulse-shaped PRBS link. Takes the oversampled signed

---
 rtl/bpsk_rx_ber_pkg.sv | 20 ++
 rtl/bpsk_rx_ber_prbs_checker.sv | 158 +++++++++++++++
 rtl/bpsk_rx_ber.sv | 97 +++++++++
 tb/tb_bpsk_rx_ber.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_rx_ber_pkg.sv
// -----------------------------------------------------------------------------
// bpsk_rx_ber_pkg
// Definitions shared by the BPSK receive/BER sink and the modulator next to it:
//   - checker FSM state encoding (LOAD, TRACK)
//   - PRBS9 defaults (x^9 + x^5 + 1)
//   - oversampling factor and phase-counter width
// -----------------------------------------------------------------------------
package bpsk_rx_ber_pkg;

   localparam int DEF_OVER_SAMP = 8;
   localparam int DEF_NB_COUNT  = 3;
   localparam int DEF_NB_PRBS   = 9;
   localparam int DEF_PRBS_TAP  = 5;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_TRACK = 1'b1
   } chk_state_e;

endpackage

// File: rtl/bpsk_rx_ber_prbs_checker.sv
// -----------------------------------------------------------------------------
// bpsk_rx_ber_prbs_checker
// Self-synchronising PRBS checker. Seeds its history register from the first
// NB_PRBS received bits, then free-runs the generator and compares each
// received bit with the prediction. Lock is judged once per LOCK_WINDOW
// symbols; bit/error counters run only while locked.
// Ports:
//   clk          in   system clock
//   rst_i        in   synchronous reset, active high
//   bit_i        in   sliced symbol
//   bit_valid_i  in   bit_i is new this cycle
//   clear_i      in   zero both counters (lock state kept)
//   locked_o     out  checker locked
//   bit_count_o  out  symbols checked while locked (saturating)
//   err_count_o  out  mismatches while locked (saturating)
// -----------------------------------------------------------------------------
module bpsk_rx_ber_prbs_checker
   import bpsk_rx_ber_pkg::*;
#(
   parameter int NB_PRBS      = DEF_NB_PRBS,
   parameter int PRBS_TAP     = DEF_PRBS_TAP,
   parameter int LOCK_WINDOW  = 64,
   parameter int LOCK_ERR_MAX = 8,
   parameter int NB_BER_CNT   = 32
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  bit_i,
   input  logic                  bit_valid_i,
   input  logic                  clear_i,
   output logic                  locked_o,
   output logic [NB_BER_CNT-1:0] bit_count_o,
   output logic [NB_BER_CNT-1:0] err_count_o
);

   localparam int NB_LCNT = $clog2(NB_PRBS);
   localparam int NB_WCNT = $clog2(LOCK_WINDOW);
   localparam int NB_WERR = $clog2(LOCK_WINDOW + 1);

   localparam logic [NB_LCNT-1:0]    LOAD_LAST = NB_LCNT'(NB_PRBS - 1);
   localparam logic [NB_LCNT-1:0]    LCNT_ONE  = NB_LCNT'(1);
   localparam logic [NB_WCNT-1:0]    WIN_LAST  = NB_WCNT'(LOCK_WINDOW - 1);
   localparam logic [NB_WCNT-1:0]    WCNT_ONE  = NB_WCNT'(1);
   localparam logic [NB_WERR-1:0]    ERR_MAX   = NB_WERR'(LOCK_ERR_MAX);
   localparam logic [NB_BER_CNT-1:0] CNT_ONE   = NB_BER_CNT'(1);

   chk_state_e            state_q, state_d;
   logic [NB_PRBS-1:0]    r_q, r_d;
   logic [NB_LCNT-1:0]    load_cnt_q, load_cnt_d;
   logic [NB_WCNT-1:0]    win_cnt_q, win_cnt_d;
   logic [NB_WERR-1:0]    win_err_q, win_err_d;
   logic                  locked_q, locked_d;
   logic [NB_BER_CNT-1:0] bit_cnt_q, bit_cnt_d;
   logic [NB_BER_CNT-1:0] err_cnt_q, err_cnt_d;

   logic                  pred;
   logic                  err;
   logic [NB_WERR-1:0]    win_err_inc;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [NB_BER_CNT-1:0] sat_inc(input logic [NB_BER_CNT-1:0] v,
                                                     input logic                  inc);
      if (inc && (v != '1)) begin
         return v + CNT_ONE;
      end
      return v;
   endfunction

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      load_cnt_d  = load_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      locked_d    = locked_q;
      bit_cnt_d   = bit_cnt_q;
      err_cnt_d   = err_cnt_q;
      pred        = r_q[NB_PRBS-1] ^ r_q[PRBS_TAP-1];
      err         = 1'b0;
      win_err_inc = win_err_q;

      if (bit_valid_i) begin
         case (state_q)
            ST_LOAD: begin
               r_d = {r_q[NB_PRBS-2:0], bit_i};
               if (load_cnt_q == LOAD_LAST) begin
                  state_d    = ST_TRACK;
                  load_cnt_d = '0;
                  win_cnt_d  = '0;
                  win_err_d  = '0;
               end else begin
                  load_cnt_d = load_cnt_q + LCNT_ONE;
               end
            end
            ST_TRACK: begin
               // The prediction, not the received bit, feeds the history so a
               // channel error never propagates into later predictions.
               err         = bit_i ^ pred;
               r_d         = {r_q[NB_PRBS-2:0], pred};
               win_err_inc = win_err_q + NB_WERR'(err);
               if (win_cnt_q == WIN_LAST) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
                  if (win_err_inc > ERR_MAX) begin
                     locked_d   = 1'b0;
                     state_d    = ST_LOAD;
                     load_cnt_d = '0;
                  end else begin
                     locked_d = 1'b1;
                  end
               end else begin
                  win_cnt_d = win_cnt_q + WCNT_ONE;
                  win_err_d = win_err_inc;
               end
               // Uses the lock flag from before this symbol, so the window
               // that drops lock is still counted.
               if (locked_q) begin
                  bit_cnt_d = sat_inc(bit_cnt_q, 1'b1);
                  err_cnt_d = sat_inc(err_cnt_q, err);
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end

      if (clear_i) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q    <= ST_LOAD;
         r_q        <= '0;
         load_cnt_q <= '0;
         win_cnt_q  <= '0;
         win_err_q  <= '0;
         locked_q   <= 1'b0;
         bit_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         load_cnt_q <= load_cnt_d;
         win_cnt_q  <= win_cnt_d;
         win_err_q  <= win_err_d;
         locked_q   <= locked_d;
         bit_cnt_q  <= bit_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign locked_o    = locked_q;
   assign bit_count_o = bit_cnt_q;
   assign err_count_o = err_cnt_q;

endmodule

// File: rtl/bpsk_rx_ber.sv
// -----------------------------------------------------------------------------
// bpsk_rx_ber
// Receive end of the BPSK pulse-shaped PRBS loopback. Decimates the
// oversampled sample stream on a selectable phase, hard-slices each symbol
// (negative -> 1, zero/positive -> 0) and feeds the PRBS checker whose lock
// flag and bit/error counters are read by the host.
// Ports:
//   clk          in   system clock
//   i_rst        in   synchronous reset, active high
//   i_enable     in   sample strobe (oversampled rate)
//   i_data       in   signed sample, valid when i_enable=1
//   i_phase      in   sampling phase, 0..OVER_SAMP-1
//   i_clear      in   zero bit/error counters (lock state kept)
//   o_bit        out  sliced symbol
//   o_bit_valid  out  1-cycle pulse, o_bit is new
//   o_locked     out  PRBS checker locked
//   o_bit_count  out  symbols checked while locked (saturating)
//   o_err_count  out  mismatches while locked (saturating)
// -----------------------------------------------------------------------------
module bpsk_rx_ber
   import bpsk_rx_ber_pkg::*;
#(
   parameter int NB_INPUT     = 13,
   parameter int OVER_SAMP    = DEF_OVER_SAMP,
   parameter int NB_COUNT     = DEF_NB_COUNT,
   parameter int NB_PRBS      = DEF_NB_PRBS,
   parameter int PRBS_TAP     = DEF_PRBS_TAP,
   parameter int LOCK_WINDOW  = 64,
   parameter int LOCK_ERR_MAX = 8,
   parameter int NB_BER_CNT   = 32
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_enable,
   input  logic signed [NB_INPUT-1:0] i_data,
   input  logic        [NB_COUNT-1:0] i_phase,
   input  logic                       i_clear,
   output logic                       o_bit,
   output logic                       o_bit_valid,
   output logic                       o_locked,
   output logic      [NB_BER_CNT-1:0] o_bit_count,
   output logic      [NB_BER_CNT-1:0] o_err_count
);

   localparam logic [NB_COUNT-1:0]        CNT_LAST = NB_COUNT'(OVER_SAMP - 1);
   localparam logic [NB_COUNT-1:0]        CNT_ONE  = NB_COUNT'(1);
   localparam logic signed [NB_INPUT-1:0] ZERO_S   = '0;

   logic [NB_COUNT-1:0] phase_cnt_q, phase_cnt_d;
   logic                bit_q, bit_d;
   logic                bit_vld_q, bit_vld_d;
   logic                take;

   always_comb begin
      phase_cnt_d = phase_cnt_q;
      if (i_enable) begin
         phase_cnt_d = (phase_cnt_q == CNT_LAST) ? '0 : phase_cnt_q + CNT_ONE;
      end
      take      = i_enable && (phase_cnt_q == i_phase);
      bit_vld_d = take;
      // Sign test: zero slices to 0, any negative sample to 1.
      bit_d     = take ? (i_data < ZERO_S) : bit_q;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         phase_cnt_q <= '0;
         bit_q       <= 1'b0;
         bit_vld_q   <= 1'b0;
      end else begin
         phase_cnt_q <= phase_cnt_d;
         bit_q       <= bit_d;
         bit_vld_q   <= bit_vld_d;
      end
   end

   assign o_bit       = bit_q;
   assign o_bit_valid = bit_vld_q;

   bpsk_rx_ber_prbs_checker #(
      .NB_PRBS      (NB_PRBS),
      .PRBS_TAP     (PRBS_TAP),
      .LOCK_WINDOW  (LOCK_WINDOW),
      .LOCK_ERR_MAX (LOCK_ERR_MAX),
      .NB_BER_CNT   (NB_BER_CNT)
   ) u_checker (
      .clk         (clk),
      .rst_i       (i_rst),
      .bit_i       (bit_q),
      .bit_valid_i (bit_vld_q),
      .clear_i     (i_clear),
      .locked_o    (o_locked),
      .bit_count_o (o_bit_count),
      .err_count_o (o_err_count)
   );

endmodule

// File: tb/tb_bpsk_rx_ber.sv
// -----------------------------------------------------------------------------
// tb_bpsk_rx_ber
// Bench for bpsk_rx_ber: a 32-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream. Expected lock/count values come from a
// queue-based model of the PRBS checker rules.
// -----------------------------------------------------------------------------
module tb_bpsk_rx_ber;

   logic               clk = 1'b0;
   logic               i_rst;
   logic               i_enable;
   logic signed [12:0] i_data;
   logic [2:0]         i_phase;
   logic               i_clear;

   logic        o_bit, o_bit_valid, o_locked;
   logic [31:0] o_bit_count, o_err_count;
   logic        s_bit, s_bit_valid, s_locked;
   logic [3:0]  s_bit_count, s_err_count;

   always #5 clk = ~clk;

   bpsk_rx_ber dut (
      .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_data(i_data),
      .i_phase(i_phase), .i_clear(i_clear), .o_bit(o_bit),
      .o_bit_valid(o_bit_valid), .o_locked(o_locked),
      .o_bit_count(o_bit_count), .o_err_count(o_err_count)
   );

   bpsk_rx_ber #(.NB_BER_CNT(4)) dut_small (
      .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_data(i_data),
      .i_phase(i_phase), .i_clear(i_clear), .o_bit(s_bit),
      .o_bit_valid(s_bit_valid), .o_locked(s_locked),
      .o_bit_count(s_bit_count), .o_err_count(s_err_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model of the checker rules ----------------
   bit     m_load;
   bit     seed[$];
   bit     pred[$];
   int     m_wpos, m_werr;
   bit     m_locked;
   longint m_bc, m_ec, m_bc4, m_ec4;

   function automatic void model_reset();
      m_load = 1'b1; seed.delete(); pred.delete();
      m_wpos = 0; m_werr = 0; m_locked = 1'b0;
      m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
   endfunction

   function automatic void model_step(input bit b);
      bit e, er;
      if (m_load) begin
         seed.push_back(b);
         if (seed.size() == 9) begin
            pred = seed; m_load = 1'b0; m_wpos = 0; m_werr = 0;
         end
      end else begin
         // s[n] = s[n-9] ^ s[n-5]
         e  = pred[pred.size()-9] ^ pred[pred.size()-5];
         er = b ^ e;
         pred.push_back(e);
         if (pred.size() > 32) void'(pred.pop_front());
         if (m_locked) begin
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (m_bc4 < 15) m_bc4++;
            if (er && m_ec < 64'hFFFF_FFFF) m_ec++;
            if (er && m_ec4 < 15) m_ec4++;
         end
         m_werr += int'(er);
         m_wpos++;
         if (m_wpos == 64) begin
            m_locked = (m_werr <= 8);
            if (!m_locked) begin m_load = 1'b1; seed.delete(); end
            m_wpos = 0; m_werr = 0;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   int ph, tb_k, n_valid;
   bit pend, clr_req, last_bit;
   bit tx[$];

   task automatic step(input bit en, input logic signed [12:0] d);
      bit exp_v;
      i_clear = 1'b0;
      if (clr_req && o_bit_valid) begin
         i_clear = 1'b1; clr_req = 1'b0;
         m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
      end
      i_enable = en;
      i_data   = d;
      exp_v    = en && (tb_k == ph);
      if (en) tb_k = (tb_k + 1) % 8;
      @(negedge clk);
      if (pend) begin
         check("locked",    o_locked,    m_locked);
         check("bit_count", o_bit_count, m_bc);
         check("err_count", o_err_count, m_ec);
         check("locked_s",  s_locked,    m_locked);
         check("bit_cnt_s", s_bit_count, m_bc4);
         check("err_cnt_s", s_err_count, m_ec4);
         pend = 1'b0;
      end
      check("bit_valid", o_bit_valid, exp_v);
      if (o_bit_valid) begin n_valid++; last_bit = o_bit; end
      if (exp_v) begin
         check("bit", o_bit, d[12]);
         model_step(d[12]);
         pend = 1'b1;
      end
   endtask

   task automatic flush();
      step(1'b0, 13'sd0);
   endtask

   task automatic do_reset(input int phase);
      i_rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         i_enable = 1'($urandom); i_data = 13'($urandom);
         i_clear  = 1'($urandom); i_phase = 3'($urandom);
         @(negedge clk);
         check("rst_bit",       o_bit,       0);
         check("rst_bit_valid", o_bit_valid, 0);
         check("rst_locked",    o_locked,    0);
         check("rst_bit_count", o_bit_count, 0);
         check("rst_err_count", o_err_count, 0);
         check("rst_err_cnt_s", s_err_count, 0);
      end
      i_rst = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_data = '0;
      i_phase = 3'(phase); ph = phase; tb_k = 0;
      pend = 1'b0; clr_req = 1'b0;
      model_reset();
   endtask

   task automatic send_sym(input bit b);
      int a;
      logic signed [12:0] v, d;
      a = int'($urandom_range(0, 4094));
      v = b ? 13'(-(a + 1)) : 13'(a);
      for (int j = 0; j < 8; j++) begin
         d = (tb_k == ph) ? v : 13'($urandom);
         step(1'b1, d);
      end
   endtask

   function automatic bit prbs_next();
      bit nb;
      nb = tx[tx.size()-9] ^ tx[tx.size()-5];
      tx.push_back(nb);
      if (tx.size() > 16) void'(tx.pop_front());
      return nb;
   endfunction

   task automatic send_one(input bit inv);
      send_sym(prbs_next() ^ inv);
   endtask

   typedef struct {
      int phase;
      int sel;
      int other;
      int gap;
      bit exp_bit;
   } dec_vec_t;

   dec_vec_t tbl[5];

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint e0, b0;
      int     nv0, n;
      bit     lost;
      i_rst = 1'b1; i_enable = 1'b0; i_data = '0; i_phase = '0; i_clear = 1'b0;
      for (int i = 0; i < 9; i++) tx.push_back(1'b1);

      tbl[0] = '{3,    -5,     7, 0, 1'b1};
      tbl[1] = '{0,     7,    -5, 1, 1'b0};
      tbl[2] = '{7,     0,    -1, 0, 1'b0};
      tbl[3] = '{5, -4096,  4095, 2, 1'b1};
      tbl[4] = '{1,  4095, -4096, 0, 1'b0};

      // Decimation table: 16 enables -> exactly two valids of the selected sign.
      for (int t = 0; t < 5; t++) begin
         do_reset(tbl[t].phase);
         nv0 = n_valid;
         for (int e = 0; e < 16; e++) begin
            step(1'b1, (tb_k == ph) ? 13'(tbl[t].sel) : 13'(tbl[t].other));
            for (int g = 0; g < tbl[t].gap; g++) step(1'b0, 13'(tbl[t].other));
         end
         flush();
         check("dec_valids", n_valid - nv0, 2);
         check("dec_bit", last_bit, tbl[t].exp_bit);
      end

      // Acquisition on a random phase.
      do_reset(int'($urandom_range(0, 7)));
      for (int i = 0; i < 72; i++) send_one(1'b0);
      flush();
      check("acq_not_yet", o_locked, 0);
      send_one(1'b0);
      flush();
      check("acq_locked", o_locked, 1);
      check("acq_count0", o_bit_count, 0);
      for (int i = 0; i < 50; i++) send_one(1'b0);
      flush();
      check("acq_bits50", o_bit_count, 50);
      check("acq_errs0", o_err_count, 0);

      // Sparse errors: 1 in 100.
      e0 = o_err_count; b0 = o_bit_count;
      for (int i = 0; i < 1000; i++) send_one(i % 100 == 99);
      flush();
      check("sparse_errs", longint'(o_err_count) - e0, 10);
      check("sparse_bits", longint'(o_bit_count) - b0, 1000);
      check("sparse_locked", o_locked, 1);

      // Loss of lock: every 4th symbol inverted.
      lost = 1'b0;
      for (int i = 0; i < 128; i++) begin
         send_one(i % 4 == 3);
         flush();
         if (!o_locked) begin lost = 1'b1; break; end
      end
      check("loss", lost, 1);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         send_one(1'b0);
         flush();
         n++;
         if (o_locked) break;
      end
      check("relock_syms", n, 73);

      // Clear coincident with a valid symbol.
      clr_req = 1'b1;
      send_one(1'b0);
      flush();
      flush();
      check("clr_bits", o_bit_count, 0);
      check("clr_errs", o_err_count, 0);
      check("clr_bits_s", s_bit_count, 0);
      check("clr_errs_s", s_err_count, 0);
      check("clr_locked", o_locked, 1);

      // Saturation of the 4-bit counters: 20 errors, then 5 more.
      for (int i = 0; i < 160; i++) send_one(i % 8 == 7);
      flush();
      check("sat_errs_s", s_err_count, 15);
      check("sat_bits_s", s_bit_count, 15);
      check("sat_errs", o_err_count, 20);
      for (int i = 0; i < 40; i++) send_one(i % 8 == 7);
      flush();
      check("sat_hold_s", s_err_count, 15);
      check("sat_errs25", o_err_count, 25);
      check("sat_locked", o_locked, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
